// File: rtl/learn_sequencer.sv
// rtl/learn_sequencer.sv - Sample fetch / evaluate / learn sequencer for perceptron training
module learn_sequencer #(
  parameter int N_NEURONS   = 20,
  parameter int NUM_SAMPLES = 16,
  parameter int MAX_EPOCHS  = 255,
  parameter int Y_LATENCY   = 2,
  localparam int IDX_W      = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
  localparam int ERR_W      = $clog2(NUM_SAMPLES + 1),
  localparam int LAT_W      = $clog2(Y_LATENCY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sample_valid,
  input  logic [N_NEURONS-1:0] sample_neurons,
  input  logic                 sample_x,
  output logic                 sample_ready,
  output logic [IDX_W-1:0]     sample_idx,
  input  logic [8:0]           y,
  output logic [N_NEURONS-1:0] neurons,
  output logic                 x_in,
  output logic                 learn_mode,
  output logic [7:0]           epoch,
  output logic [ERR_W-1:0]     err_count,
  output logic                 busy,
  output logic                 done,
  output logic                 converged
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_NORM, S_EVAL, S_LEARN, S_EPOCH_END, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [N_NEURONS-1:0]   neurons_q, neurons_d;
  logic                   x_in_q, x_in_d;
  logic                   learn_mode_q, learn_mode_d;
  logic [IDX_W-1:0]       sample_idx_q, sample_idx_d;
  logic [7:0]             epoch_q, epoch_d;
  logic [ERR_W-1:0]       err_count_q, err_count_d;
  logic [LAT_W-1:0]       eval_cnt_q, eval_cnt_d;
  logic                   converged_q, converged_d;

  logic                   last_sample;
  logic                   last_epoch;
  logic                   y_mag_unused;

  // Only the sign of y matters to the sequencer.
  assign y_mag_unused = ^y[7:0];
  assign last_sample  = (sample_idx_q == IDX_W'(NUM_SAMPLES - 1));
  assign last_epoch   = (epoch_q == 8'(MAX_EPOCHS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      neurons_q    <= '0;
      x_in_q       <= 1'b0;
      learn_mode_q <= 1'b0;
      sample_idx_q <= '0;
      epoch_q      <= '0;
      err_count_q  <= '0;
      eval_cnt_q   <= '0;
      converged_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      neurons_q    <= neurons_d;
      x_in_q       <= x_in_d;
      learn_mode_q <= learn_mode_d;
      sample_idx_q <= sample_idx_d;
      epoch_q      <= epoch_d;
      err_count_q  <= err_count_d;
      eval_cnt_q   <= eval_cnt_d;
      converged_q  <= converged_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_FETCH;
      S_FETCH:        if (sample_valid) state_d = S_NORM;
      S_NORM:         state_d = S_EVAL;
      S_EVAL:         if (eval_cnt_q == '0) state_d = S_LEARN;
      S_LEARN:        state_d = last_sample ? S_EPOCH_END : S_FETCH;
      S_EPOCH_END: begin
        if (err_count_q == '0 || last_epoch) state_d = S_DONE;
        else                                 state_d = S_FETCH;
      end
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    neurons_d    = neurons_q;
    x_in_d       = x_in_q;
    sample_idx_d = sample_idx_q;
    epoch_d      = epoch_q;
    err_count_d  = err_count_q;
    eval_cnt_d   = eval_cnt_q;
    converged_d  = converged_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sample_idx_d = '0;
          epoch_d      = '0;
          err_count_d  = '0;
          converged_d  = 1'b0;
        end
      end
      S_FETCH: begin
        if (sample_valid) begin
          neurons_d  = sample_neurons;
          x_in_d     = sample_x;
          eval_cnt_d = LAT_W'(Y_LATENCY - 1);
        end
      end
      S_EVAL: begin
        // A sign mistake is the datapath sign disagreeing with the label.
        if (eval_cnt_q == '0) begin
          if ((y[8] ^ x_in_q) && (err_count_q != ERR_W'(NUM_SAMPLES)))
            err_count_d = err_count_q + 1'b1;
        end else begin
          eval_cnt_d = eval_cnt_q - 1'b1;
        end
      end
      S_LEARN: begin
        if (!last_sample) sample_idx_d = sample_idx_q + 1'b1;
      end
      S_EPOCH_END: begin
        sample_idx_d = '0;
        if (err_count_q == '0) begin
          converged_d = 1'b1;
        end else if (!last_epoch) begin
          epoch_d     = epoch_q + 1'b1;
          err_count_d = '0;
        end
      end
      default: ;
    endcase
    learn_mode_d = (state_d == S_LEARN);
  end

  always_comb begin
    sample_ready = (state_q == S_FETCH);
    busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    done         = (state_q == S_DONE);
    sample_idx   = sample_idx_q;
    neurons      = neurons_q;
    x_in         = x_in_q;
    learn_mode   = learn_mode_q;
    epoch        = epoch_q;
    err_count    = err_count_q;
    converged    = converged_q;
  end

endmodule

// File: tb/tb_learn_sequencer.sv
// tb/tb_learn_sequencer.sv - Randomized self-checking bench for learn_sequencer
module tb_learn_sequencer;
  localparam int NN = 20;
  localparam int NS = 16;
  localparam int ME = 3;
  localparam int YL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          sample_valid = 1'b0;
  logic [NN-1:0] sample_neurons;
  logic          sample_x;
  logic          sample_ready;
  logic [3:0]    sample_idx;
  logic [8:0]    y;
  logic [NN-1:0] neurons;
  logic          x_in;
  logic          learn_mode;
  logic [7:0]    epoch;
  logic [4:0]    err_count;
  logic          busy, done, converged;

  learn_sequencer #(.N_NEURONS(NN), .NUM_SAMPLES(NS), .MAX_EPOCHS(ME), .Y_LATENCY(YL)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .sample_neurons(sample_neurons), .sample_x(sample_x), .sample_ready(sample_ready),
    .sample_idx(sample_idx), .y(y), .neurons(neurons), .x_in(x_in),
    .learn_mode(learn_mode), .epoch(epoch), .err_count(err_count),
    .busy(busy), .done(done), .converged(converged)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            lp, exp_idx, idx_bad, cap_bad;
  logic [NN-1:0] mem_n [NS];
  logic          mem_x [NS];
  logic [NN-1:0] cap_n;
  logic          cap_x;
  logic [NS-1:0] mask;
  int            y_mode;
  logic [7:0]    y_low;
  logic          flip;

  // Sample source answers the requested index; the datapath model flips the sign on chosen samples.
  assign sample_neurons = mem_n[sample_idx];
  assign sample_x       = mem_x[sample_idx];
  always_comb begin
    flip = 1'b0;
    case (y_mode)
      1:       flip = 1'b1;
      2:       flip = (epoch == 8'd0) && mask[sample_idx];
      default: flip = 1'b0;
    endcase
    y = {x_in ^ flip, y_low};
  end

  task automatic tick();
    logic hs;
    hs = sample_valid && sample_ready && !rst;
    if (hs) begin
      if (sample_idx !== 4'(exp_idx)) idx_bad++;
      cap_n   = sample_neurons;
      cap_x   = sample_x;
      exp_idx = (exp_idx + 1) % NS;
    end
    y_low = 8'($urandom);
    @(negedge clk);
    if (hs && (neurons !== cap_n || x_in !== cap_x)) cap_bad++;
    if (learn_mode) lp++;
  endtask

  task automatic start_run(input logic v);
    sample_valid = v;
    start   = 1'b1;
    exp_idx = 0;
    lp      = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int bound, input bit rnd, output int n);
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      if (rnd) sample_valid = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    sample_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sample_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, done, converged, learn_mode, sample_ready, x_in} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {busy, done, converged, learn_mode, sample_ready, x_in});
    end
    checks++;
    if ({neurons, epoch, err_count, sample_idx} !== '0) begin
      errors++; $display("FAIL reset_values: neurons %h epoch %0d err %0d idx %0d want all 0", neurons, epoch, err_count, sample_idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_converge_and_ignored_start();
    int n;
    y_mode = 0; idx_bad = 0; cap_bad = 0;
    start_run(1'b1);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      start = (n == 30);
      tick();
      n++;
    end
    start = 1'b0;
    checks++; if (n !== 81) begin errors++; $display("FAIL converge_cycles: got %0d want 81", n); end
    checks++; if (converged !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL converge_status: conv %b busy %b want 1 0", converged, busy); end
    checks++; if (epoch !== 8'd0 || err_count !== 5'd0) begin errors++; $display("FAIL converge_counts: epoch %0d err %0d want 0 0", epoch, err_count); end
    checks++; if (lp !== 16) begin errors++; $display("FAIL converge_learn_pulses: got %0d want 16", lp); end
    checks++; if (neurons !== mem_n[NS-1] || x_in !== mem_x[NS-1]) begin errors++; $display("FAIL converge_hold: neurons %h want %h", neurons, mem_n[NS-1]); end
    checks++; if (idx_bad !== 0 || cap_bad !== 0) begin errors++; $display("FAIL converge_order: idx_bad %0d cap_bad %0d want 0 0", idx_bad, cap_bad); end
  endtask

  task automatic test_restart_from_done();
    int n;
    y_mode = 0;
    start_run(1'b1);
    checks++; if ({done, busy, converged, sample_ready} !== 4'b0101) begin errors++; $display("FAIL restart_flags: got %b want 0101", {done, busy, converged, sample_ready}); end
    checks++; if (epoch !== 8'd0 || sample_idx !== 4'd0) begin errors++; $display("FAIL restart_counts: epoch %0d idx %0d want 0 0", epoch, sample_idx); end
    run_to_done(200, 1'b0, n);
    checks++; if (n !== 81 || converged !== 1'b1) begin errors++; $display("FAIL restart_finish: cycles %0d conv %b want 81 1", n, converged); end
  endtask

  task automatic test_stall();
    int n, bad_ready, bad_idx;
    y_mode = 0; bad_ready = 0; bad_idx = 0;
    start_run(1'b0);
    for (int i = 0; i < 7; i++) begin
      if (sample_ready !== 1'b1) bad_ready++;
      if (sample_idx !== 4'd0) bad_idx++;
      tick();
    end
    checks++; if (bad_ready !== 0 || bad_idx !== 0) begin errors++; $display("FAIL stall_wait: ready_bad %0d idx_bad %0d want 0 0", bad_ready, bad_idx); end
    checks++; if (lp !== 0) begin errors++; $display("FAIL stall_learn: got %0d pulses want 0", lp); end
    sample_valid = 1'b1;
    tick();
    checks++; if (neurons !== mem_n[0] || x_in !== mem_x[0]) begin errors++; $display("FAIL stall_capture: neurons %h x %b want %h %b", neurons, x_in, mem_n[0], mem_x[0]); end
    run_to_done(200, 1'b0, n);
    checks++; if (n !== 80 || converged !== 1'b1) begin errors++; $display("FAIL stall_finish: cycles %0d conv %b want 80 1", n, converged); end
  endtask

  task automatic test_no_converge();
    int n;
    y_mode = 1;
    start_run(1'b1);
    run_to_done(400, 1'b0, n);
    checks++; if (n !== 3 * 81) begin errors++; $display("FAIL noconv_cycles: got %0d want %0d", n, 3 * 81); end
    checks++; if (done !== 1'b1 || converged !== 1'b0) begin errors++; $display("FAIL noconv_status: done %b conv %b want 1 0", done, converged); end
    checks++; if (epoch !== 8'(ME - 1) || err_count !== 5'(NS)) begin errors++; $display("FAIL noconv_counts: epoch %0d err %0d want %0d %0d", epoch, err_count, ME - 1, NS); end
    checks++; if (lp !== 3 * NS) begin errors++; $display("FAIL noconv_learn_pulses: got %0d want %0d", lp, 3 * NS); end
  endtask

  task automatic test_two_epochs(input logic [NS-1:0] m, input bit rnd, input string tag);
    int n, k;
    y_mode = 2; mask = m; idx_bad = 0; cap_bad = 0;
    start_run(1'b1);
    n = 0;
    while (lp < NS && n < 2000) begin
      if (rnd) sample_valid = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    sample_valid = 1'b1;
    tick(); n++;
    checks++; if (err_count !== 5'($countones(m)) || epoch !== 8'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_epoch_end: err %0d epoch %0d busy %b want %0d 0 1", tag, err_count, epoch, busy, $countones(m));
    end
    tick(); n++;
    checks++; if (epoch !== 8'd1 || err_count !== 5'd0 || sample_idx !== 4'd0 || sample_ready !== 1'b1) begin
      errors++; $display("FAIL %s_next_epoch: epoch %0d err %0d idx %0d ready %b want 1 0 0 1", tag, epoch, err_count, sample_idx, sample_ready);
    end
    run_to_done(2000, rnd, k);
    checks++; if (done !== 1'b1 || converged !== 1'b1 || epoch !== 8'd1) begin errors++; $display("FAIL %s_finish: done %b conv %b epoch %0d want 1 1 1", tag, done, converged, epoch); end
    if (!rnd) begin
      checks++; if (n + k !== 2 * 81) begin errors++; $display("FAIL %s_cycles: got %0d want %0d", tag, n + k, 2 * 81); end
    end
    checks++; if (idx_bad !== 0 || cap_bad !== 0 || lp !== 2 * NS) begin errors++; $display("FAIL %s_order: idx_bad %0d cap_bad %0d pulses %0d want 0 0 %0d", tag, idx_bad, cap_bad, lp, 2 * NS); end
  endtask

  task automatic test_reset_mid_eval();
    y_mode = 0;
    start_run(1'b1);
    repeat (27) tick();
    checks++; if (sample_idx !== 4'd5 || lp !== 5) begin errors++; $display("FAIL midrst_position: idx %0d pulses %0d want 5 5", sample_idx, lp); end
    rst = 1'b1; start = 1'b1;
    tick();
    checks++; if ({busy, done, converged, learn_mode, sample_ready, x_in} !== 6'b0 || {neurons, epoch, err_count, sample_idx} !== '0) begin
      errors++; $display("FAIL midrst_outputs: flags %b neurons %h epoch %0d err %0d idx %0d want all 0",
                         {busy, done, converged, learn_mode, sample_ready, x_in}, neurons, epoch, err_count, sample_idx);
    end
    checks++; if (lp !== 5) begin errors++; $display("FAIL midrst_learn_at_reset: got %0d pulses want 5", lp); end
    rst = 1'b0; start = 1'b0;
    repeat (5) tick();
    checks++; if (busy !== 1'b0 || lp !== 5) begin errors++; $display("FAIL midrst_idle: busy %b pulses %0d want 0 5", busy, lp); end
  endtask

  initial begin
    logic [NS-1:0] rmask;
    y_mode = 0; mask = '0; y_low = '0;
    lp = 0; exp_idx = 0; idx_bad = 0; cap_bad = 0;
    for (int i = 0; i < NS; i++) begin
      mem_n[i] = NN'($urandom);
      mem_x[i] = 1'($urandom_range(0, 1));
    end
    test_reset();
    test_converge_and_ignored_start();
    test_restart_from_done();
    test_stall();
    test_no_converge();
    test_two_epochs(16'h0208, 1'b0, "errs_3_9");
    rmask = NS'($urandom) | 16'h0001;
    test_two_epochs(rmask, 1'b1, "random_gaps");
    test_reset_mid_eval();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
